// File: rtl/vga_scan_320x240.sv
// rtl/vga_scan_320x240.sv - 640x480 VGA scan generator showing a 320x240 ROM image as 2x2 pixel blocks
module vga_scan_320x240 #(
    parameter int H_VIS = 640,
    parameter int H_FP  = 16,
    parameter int H_SW  = 96,
    parameter int H_BP  = 48,
    parameter int V_VIS = 480,
    parameter int V_FP  = 10,
    parameter int V_SW  = 2,
    parameter int V_BP  = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [8:0] x,
    output logic [7:0] y,
    input  logic [2:0] dout,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic       frame_start
);

    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SW);

    logic       pix_en_q, pix_en_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_n_q, blank_n_d;
    logic       r_q, r_d;
    logic       g_q, g_d;
    logic       b_q, b_d;
    logic       fs_q, fs_d;
    logic       visible;

    assign visible = (hcount_q < H_VIS_C) && (vcount_q < V_VIS_C);

    // vcount never reaches 512 while visible, so bit 9 is always zero here
    assign x = visible ? hcount_q[9:1] : 9'd0;
    assign y = visible ? vcount_q[8:1] : 8'd0;

    always_comb begin
        pix_en_d = ~pix_en_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    // Output stage loads on the pix_en=1 clk, when dout reflects the current counters
    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        fs_d      = pix_en_q && (hcount_q == 10'd0) && (vcount_q == 10'd0);
        if (pix_en_q) begin
            hs_d      = !((hcount_q >= HS_START) && (hcount_q < HS_END));
            vs_d      = !((vcount_q >= VS_START) && (vcount_q < VS_END));
            blank_n_d = visible;
            r_d       = visible & dout[2];
            g_d       = visible & dout[1];
            b_d       = visible & dout[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en_q  <= 1'b0;
            hcount_q  <= 10'd0;
            vcount_q  <= 10'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            r_q       <= 1'b0;
            g_q       <= 1'b0;
            b_q       <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            pix_en_q  <= pix_en_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            fs_q      <= fs_d;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_320x240.sv
// tb/tb_vga_scan_320x240.sv - scoreboard bench: full-size timing plus a shrunken-timing instance for frame/reset checks
module tb_vga_scan_320x240;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n_d, rst_n_s;

    logic [8:0] x_d, x_s;
    logic [7:0] y_d, y_s;
    logic [2:0] dout_d = 3'd0, dout_s = 3'd0;
    logic hs_d, vs_d, bn_d, r_d, g_d, b_d, fs_d;
    logic hs_s, vs_s, bn_s, r_s, g_s, b_s, fs_s;

    vga_scan_320x240 dut (
        .clk(clk), .rst_n(rst_n_d), .x(x_d), .y(y_d), .dout(dout_d),
        .vga_hs(hs_d), .vga_vs(vs_d), .vga_blank_n(bn_d),
        .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .frame_start(fs_d)
    );

    // 24 x 13 pixel total raster: frame = 624 clks
    vga_scan_320x240 #(
        .H_VIS(16), .H_FP(2), .H_SW(4), .H_BP(2),
        .V_VIS(8), .V_FP(1), .V_SW(2), .V_BP(2)
    ) dut_s (
        .clk(clk), .rst_n(rst_n_s), .x(x_s), .y(y_s), .dout(dout_s),
        .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bn_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .frame_start(fs_s)
    );

    // ROM models: 1-clk latency, colour = x[2:0] ^ y[2:0]
    always @(posedge clk) begin
        dout_d <= x_d[2:0] ^ y_d[2:0];
        dout_s <= x_s[2:0] ^ y_s[2:0];
    end

    int cyc_d, cyc_s;
    always @(posedge clk or negedge rst_n_d)
        if (!rst_n_d) cyc_d <= 0; else cyc_d <= cyc_d + 1;
    always @(posedge clk or negedge rst_n_s)
        if (!rst_n_s) cyc_s <= 0; else cyc_s <= cyc_s + 1;

    // {x[23:15], y[14:7], hs, vs, blank_n, r, g, b, frame_start}
    logic [23:0] od, os;
    assign od = {x_d, y_d, hs_d, vs_d, bn_d, r_d, g_d, b_d, fs_d};
    assign os = {x_s, y_s, hs_s, vs_s, bn_s, r_s, g_s, b_s, fs_s};

    localparam logic [23:0] RST_V = 24'h000060;
    localparam logic [23:0] M_XY  = 24'hFFFF80;
    localparam logic [23:0] M_VID = 24'h00007F;

    typedef struct {
        int          cyc;
        logic [23:0] exp;
        logic [23:0] msk;
        string       nm;
    } snap_t;

    snap_t snq [2][$];
    int    evq [10][$];   // index inst*5 + kind: 0 hs fall, 1 hs rise, 2 vs fall, 3 vs rise, 4 frame_start
    int    total = 0;
    int    bad   = 0;

    function automatic logic [23:0] ov(input int xx, input int yy, input logic hs, input logic vs,
                                       input logic bn, input logic [2:0] rgb, input logic fs);
        return {9'(xx), 8'(yy), hs, vs, bn, rgb, fs};
    endfunction

    task automatic push_snap(input int inst, input int c, input logic [23:0] e,
                             input logic [23:0] m, input string nm);
        snap_t s;
        s.cyc = c; s.exp = e; s.msk = m; s.nm = nm;
        snq[inst].push_back(s);
    endtask

    // Event at output pixel (hpos, vpos) of each frame; vpos<0 means every line
    task automatic push_ev(input int inst, input int kind, input int htot, input int vtot,
                           input int hpos, input int vpos, input int limit);
        for (int f = 0; f < 4; f++) begin
            for (int v = 0; v < vtot; v++) begin
                int c;
                if (vpos >= 0 && v != vpos) continue;
                c = 2 + 2 * (f * vtot * htot + v * htot + hpos);
                if (c <= limit) evq[inst*5 + kind].push_back(c);
            end
        end
    endtask

    task automatic ev(input int inst, input int kind, input int c);
        int e;
        total++;
        if (evq[inst*5 + kind].size() == 0) begin
            bad++;
            $display("FAIL event inst=%0d kind=%0d unexpected at cyc=%0d", inst, kind, c);
        end else begin
            e = evq[inst*5 + kind].pop_front();
            if (e != c) begin
                bad++;
                $display("FAIL event inst=%0d kind=%0d at cyc=%0d expected cyc=%0d", inst, kind, c, e);
            end
        end
    endtask

    task automatic chk_rst(input int inst, input string nm);
        logic [23:0] o;
        o = (inst != 0) ? os : od;
        total++;
        if (o !== RST_V) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h", nm, inst, o, RST_V);
        end
    endtask

    task automatic chk_empty(input int inst, input string nm);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (evq[inst*5 + k].size() != 0) begin
                bad++;
                $display("FAIL %s inst=%0d kind=%0d missing=%0d next_cyc=%0d", nm, inst, k,
                         evq[inst*5 + k].size(), evq[inst*5 + k][0]);
            end
        end
        total++;
        if (snq[inst].size() != 0) begin
            bad++;
            $display("FAIL %s inst=%0d snapshots_left=%0d next=%s", nm, inst,
                     snq[inst].size(), snq[inst][0].nm);
        end
    endtask

    // Monitor: detects output events and due snapshots, compares against queued expectations
    logic [1:0] p_hs = 2'b11, p_vs = 2'b11;
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic [23:0] o;
            int          c;
            logic        rst_ok;
            o      = (i != 0) ? os : od;
            c      = (i != 0) ? cyc_s : cyc_d;
            rst_ok = (i != 0) ? rst_n_s : rst_n_d;
            if (rst_ok) begin
                if (p_hs[i] && !o[6]) ev(i, 0, c);
                if (!p_hs[i] && o[6]) ev(i, 1, c);
                if (p_vs[i] && !o[5]) ev(i, 2, c);
                if (!p_vs[i] && o[5]) ev(i, 3, c);
                if (o[0] !== 1'b0) ev(i, 4, c);
                while (snq[i].size() > 0 && snq[i][0].cyc <= c) begin
                    snap_t s;
                    s = snq[i].pop_front();
                    total++;
                    if (s.cyc != c) begin
                        bad++;
                        $display("FAIL %s inst=%0d missed cyc=%0d now=%0d", s.nm, i, s.cyc, c);
                    end else if (((o ^ s.exp) & s.msk) !== 24'd0) begin
                        bad++;
                        $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h mask=%h", s.nm, i, c,
                                 o & s.msk, s.exp & s.msk, s.msk);
                    end
                end
            end
            p_hs[i] = o[6];
            p_vs[i] = o[5];
        end
    end

    initial begin
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;
        #3;
        rst_n_d = 1'b0;
        rst_n_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_rst(0, "reset_hold");
        chk_rst(1, "reset_hold");

        // Full-size instance: first hsync fall at 2*656+2, 1600 clk line, 192 clk pulse
        evq[0].push_back(2*656 + 2);
        evq[0].push_back(2*656 + 2 + 1600);
        evq[1].push_back(2*656 + 2 + 192);
        evq[1].push_back(2*656 + 2 + 1600 + 192);
        evq[4].push_back(2);
        push_snap(0, 2,    ov(0, 0, 1, 1, 1, 3'b000, 1), M_VID, "pix_0_0_fs");
        push_snap(0, 3,    ov(0, 0, 1, 1, 1, 3'b000, 0), M_VID, "fs_one_clk");
        push_snap(0, 1278, ov(319, 0, 0, 0, 0, 0, 0),    M_XY,  "xy_639_0");
        push_snap(0, 1280, ov(0, 0, 1, 1, 1, 3'b111, 0), M_VID, "pix_639_0");
        push_snap(0, 1282, ov(0, 0, 1, 1, 0, 3'b000, 0), M_VID, "blank_640_0");
        push_snap(0, 1314, ov(0, 0, 0, 1, 0, 3'b000, 0), M_VID, "hs_656_0");
        push_snap(0, 1626, ov(6, 0, 0, 0, 0, 0, 0),      M_XY,  "xy_13_1");
        push_snap(0, 1628, ov(0, 0, 1, 1, 1, 3'b110, 0), M_VID, "pix_13_1");
        push_snap(0, 3000, ov(0, 0, 0, 0, 0, 0, 0),      M_XY,  "xy_700_1");
        push_snap(0, 3002, ov(0, 0, 0, 1, 0, 3'b000, 0), M_VID, "blank_700_1");
        push_snap(0, 3212, ov(3, 1, 0, 0, 0, 0, 0),      M_XY,  "xy_6_2");
        push_snap(0, 3214, ov(0, 0, 1, 1, 1, 3'b010, 0), M_VID, "pix_6_2");

        // Small instance, first epoch: ~2.4 frames
        push_ev(1, 0, 24, 13, 18, -1, 1508);
        push_ev(1, 1, 24, 13, 22, -1, 1508);
        push_ev(1, 2, 24, 13, 0, 9, 1508);
        push_ev(1, 3, 24, 13, 0, 11, 1508);
        push_ev(1, 4, 24, 13, 0, 0, 1508);
        push_snap(1, 366, ov(7, 3, 0, 0, 0, 0, 0),      M_XY,  "s_xy_15_7");
        push_snap(1, 368, ov(0, 0, 1, 1, 1, 3'b100, 0), M_VID, "s_pix_15_7");
        push_snap(1, 370, ov(0, 0, 1, 1, 0, 3'b000, 0), M_VID, "s_blank_16_7");
        push_snap(1, 392, ov(0, 0, 1, 1, 0, 3'b000, 0), M_VID, "s_blank_3_8");
        push_snap(1, 434, ov(0, 0, 1, 0, 0, 3'b000, 0), M_VID, "s_vs_0_9");

        @(negedge clk);
        #2;
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;

        // Mid-frame reset of the small instance at counters (h=10, v=5)
        while (cyc_s != 1508) @(negedge clk);
        #2;
        chk_empty(1, "epoch1_drain");
        rst_n_s = 1'b0;
        #1;
        chk_rst(1, "reset_async");
        repeat (3) @(posedge clk);
        #1;
        chk_rst(1, "reset_3clk");

        push_ev(1, 0, 24, 13, 18, -1, 700);
        push_ev(1, 1, 24, 13, 22, -1, 700);
        push_ev(1, 2, 24, 13, 0, 9, 700);
        push_ev(1, 3, 24, 13, 0, 11, 700);
        push_ev(1, 4, 24, 13, 0, 0, 700);
        push_snap(1, 2,   ov(0, 0, 1, 1, 1, 3'b000, 1), M_VID, "s_restart_fs");
        push_snap(1, 154, ov(2, 1, 0, 0, 0, 0, 0),      M_XY,  "s_xy_5_3");
        push_snap(1, 156, ov(0, 0, 1, 1, 1, 3'b011, 0), M_VID, "s_pix_5_3");
        push_snap(1, 622, ov(0, 0, 0, 0, 0, 0, 0),      M_XY,  "s_xy_last");
        push_snap(1, 624, ov(0, 0, 0, 0, 0, 0, 0),      M_XY,  "s_xy_wrap");
        push_snap(1, 626, ov(0, 0, 1, 1, 1, 3'b000, 1), M_VID, "s_wrap_fs");

        @(negedge clk);
        #2;
        rst_n_s = 1'b1;

        while (cyc_s != 700) @(negedge clk);
        #2;
        rst_n_s = 1'b0;
        chk_empty(1, "epoch2_drain");

        while (cyc_d != 3300) @(negedge clk);
        #2;
        chk_empty(0, "full_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
